// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
//
// Purpose: groups the operand request and the result/flag signals of
//          serial_subtractor so the block and its user share one port.
// Optional feature macro: SERIAL_ADDSUB_EN adds op_sub (1 = subtract, 0 = add).
// Signals:
//   start            request, sampled by the block only while idle
//   A, B             minuend / subtrahend, captured on the accepting edge
//   op_sub           operation select (SERIAL_ADDSUB_EN builds only)
//   busy             operation in flight
//   done             one-cycle pulse, results valid
//   diff             result, held until the next done
//   negative/zero/carry/overflow   N, Z, C (1 = no borrow), V flags
// Modports: master = requester, slave = serial_subtractor.

interface serial_subtractor_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_ADDSUB_EN
    logic             op_sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             negative;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output start, A, B,
`ifdef SERIAL_ADDSUB_EN
        output op_sub,
`endif
        input  busy, done, diff, negative, zero, carry, overflow
    );

    modport slave (
        input  start, A, B,
`ifdef SERIAL_ADDSUB_EN
        input  op_sub,
`endif
        output busy, done, diff, negative, zero, carry, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor with NZCV flags
//
// Purpose: computes A - B one bit per clock, LSB first, through a single
//          full-adder slice fed with ~B and a carry-in of 1. Results and
//          ARM-style flags are published together on a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDSUB_EN - adds bus.op_sub; when 0 the slice
//          adds (B not inverted, carry-in 0). Undefined: always subtracts.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any operation in flight
//   bus      serial_subtractor_if.slave: start/A/B[/op_sub] in,
//            busy/done/diff/negative/zero/carry/overflow out

module serial_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    serial_subtractor_if.slave  bus
);
    localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PRE  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             c_reg;
    logic             c_msb_in;
    logic [CW-1:0]    cnt;
`ifdef SERIAL_ADDSUB_EN
    logic             sub_reg;
`endif

    logic [WIDTH-1:0] diff_reg;
    logic             n_reg;
    logic             z_reg;
    logic             c_flag_reg;
    logic             v_reg;

    logic             b_eff;
    logic             sum_bit;
    logic             c_next;
    logic [WIDTH-1:0] final_diff;
    logic             last_bit;

    // Single full-adder slice. In subtract mode B is inverted; the +1 comes
    // from the carry register being preset to 1 on accept.
    always_comb begin
`ifdef SERIAL_ADDSUB_EN
        b_eff = sub_reg ? ~b_sh[0] : b_sh[0];
`else
        b_eff = ~b_sh[0];
`endif
        sum_bit    = a_sh[0] ^ b_eff ^ c_reg;
        c_next     = (a_sh[0] & b_eff) | (a_sh[0] & c_reg) | (b_eff & c_reg);
        // Result as it will look once this edge's bit has been shifted in;
        // on the last bit this is the complete answer.
        final_diff = {sum_bit, res_sh[WIDTH-1:1]};
        last_bit   = (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: busy covers exactly the RUN cycles, done exactly FIN.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            FIN:     bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand/result shifters, carry, counter and published results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            c_reg      <= 1'b0;
            c_msb_in   <= 1'b0;
            cnt        <= '0;
`ifdef SERIAL_ADDSUB_EN
            sub_reg    <= 1'b0;
`endif
            diff_reg   <= '0;
            n_reg      <= 1'b0;
            z_reg      <= 1'b0;
            c_flag_reg <= 1'b0;
            v_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        cnt   <= '0;
`ifdef SERIAL_ADDSUB_EN
                        sub_reg <= bus.op_sub;
                        c_reg   <= bus.op_sub;
`else
                        c_reg   <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= final_diff;
                    c_reg  <= c_next;
                    cnt    <= cnt + CW'(1);
                    // Carry leaving bit WIDTH-2 is the carry into the MSB,
                    // needed for the overflow flag.
                    if (cnt == PRE) begin
                        c_msb_in <= c_next;
                    end
                    if (last_bit) begin
                        diff_reg   <= final_diff;
                        n_reg      <= sum_bit;
                        z_reg      <= (final_diff == '0);
                        c_flag_reg <= c_next;
                        v_reg      <= c_msb_in ^ c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff     = diff_reg;
    assign bus.negative = n_reg;
    assign bus.zero     = z_reg;
    assign bus.carry    = c_flag_reg;
    assign bus.overflow = v_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH = 8)

module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] prev_diff;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation starting from IDLE, checking busy/done timing,
    // that diff holds its old value mid-run, and the final result and flags.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic en, input logic ez,
                          input logic ec, input logic ev);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        check({tag, " busy_after_accept"}, 64'(bus.busy), 64'd1);
        repeat (W - 1) @(posedge clk);
        #1;
        check({tag, " done_early"}, 64'(bus.done), 64'd0);
        check({tag, " diff_held"}, 64'(bus.diff), 64'(prev_diff));
        @(posedge clk); #1;
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, " diff"}, 64'(bus.diff), 64'(ed));
        check({tag, " nzcv"}, 64'({bus.negative, bus.zero, bus.carry, bus.overflow}),
              64'({en, ez, ec, ev}));
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
        check({tag, " diff_hold_after"}, 64'(bus.diff), 64'(ed));
        prev_diff = ed;
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
`ifdef SERIAL_ADDSUB_EN
        bus.op_sub = 1'b1;
`endif
        prev_diff = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 64'({bus.busy, bus.done, bus.diff, bus.negative, bus.zero,
              bus.carry, bus.overflow}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        //      tag        A      B      diff   N     Z     C     V
        run_op("5-3",   8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("3-5",   8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("80-1",  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("2A-2A", 8'h2A, 8'h2A, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("5C-0",  8'h5C, 8'h00, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("0-1",   8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);

        // start re-asserted mid-run with new operands must be ignored
        bus.A = 8'h10;
        bus.B = 8'h04;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.A = 8'hFF;
        bus.B = 8'h01;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("ignore diff_held", 64'(bus.diff), 64'(prev_diff));
        repeat (W - 4) @(posedge clk);
        #1;
        check("ignore done_early", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        check("ignore done", 64'(bus.done), 64'd1);
        check("ignore diff", 64'(bus.diff), 64'h0C);
        check("ignore nzcv", 64'({bus.negative, bus.zero, bus.carry, bus.overflow}), 64'b0010);
        @(posedge clk); #1;
        check("ignore no_restart", 64'(bus.busy), 64'd0);
        prev_diff = 8'h0C;

        // reset in the middle of RUN aborts with no done and zeroes outputs
        bus.A = 8'h09;
        bus.B = 8'h02;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset outputs", 64'({bus.busy, bus.done, bus.diff, bus.negative, bus.zero,
              bus.carry, bus.overflow}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        begin
            int seen_done = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(posedge clk); #1;
                if (bus.done) seen_done++;
            end
            check("midreset no_done", 64'(seen_done), 64'd0);
        end
        prev_diff = '0;
        run_op("post-reset 5-3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SERIAL_ADDSUB_EN
        bus.op_sub = 1'b0;
        run_op("add 7F+1", 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.op_sub = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
